// File: rtl/tft_char_scroll.sv
// tft_char_scroll: character/bitmap overlay on the TFT pixel path.
// Renders a CHAR_W x CHAR_H bitmap from an external synchronous row ROM into a
// fixed window, scrolling horizontally by SCROLL_STEP every SCROLL_DIV frames
// with wrap-around. Three-stage pipeline: coordinate -> pix_data in 3 clocks.
// Optional blink: define TFT_CHAR_BLINK_EN to hide the foreground on alternate
// BLINK_FRAMES-long periods.
module tft_char_scroll #(
    parameter int H_VALID      = 480,
    parameter int V_VALID      = 272,
    parameter int WIN_X        = 112,
    parameter int WIN_Y        = 104,
    parameter int CHAR_W       = 256,
    parameter int CHAR_H       = 64,
    parameter int ADDR_W       = 6,
    parameter int SCROLL_DIV   = 4,
    parameter int SCROLL_STEP  = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                       tft_clk,
    input  logic                       sys_rst_n,
    input  logic [9:0]                 i_pix_x,
    input  logic [9:0]                 i_pix_y,
    input  logic                       i_scroll_en,
    input  logic                       i_scroll_dir,
    input  logic [15:0]                i_fg_color,
    input  logic [15:0]                i_bg_color,
    output logic [ADDR_W-1:0]          o_rom_addr,
    input  logic [CHAR_W-1:0]          i_rom_data,
    output logic [15:0]                o_pix_data,
    output logic [$clog2(CHAR_W)-1:0]  o_scroll_ofs
);

    localparam int OFS_W = $clog2(CHAR_W);
    localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [9:0]       WX_LO   = 10'(WIN_X);
    localparam logic [10:0]      WX_HI   = 11'(WIN_X + CHAR_W);
    localparam logic [9:0]       WY_LO   = 10'(WIN_Y);
    localparam logic [10:0]      WY_HI   = 11'(WIN_Y + CHAR_H);
    localparam logic [9:0]       X_LAST  = 10'(H_VALID - 1);
    localparam logic [9:0]       Y_LAST  = 10'(V_VALID - 1);
    localparam logic [OFS_W-1:0] STEP    = OFS_W'(SCROLL_STEP);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SCROLL_DIV - 1);

    logic              w_in_win;
    logic              w_frame_end;
    logic              w_vis;
    logic [OFS_W-1:0]  w_idx;

    logic [OFS_W-1:0]  r_scroll_ofs;
    logic [CNT_W-1:0]  r_frm_cnt;
    logic [OFS_W-1:0]  r_idx;
    logic [OFS_W-1:0]  r_idx_d2;
    logic              r_win_d1;
    logic              r_win_d2;

    // Window membership, frame-boundary detect and wrapped bitmap column.
    // The 3FF "invalid" marker is rejected explicitly so it can never alias
    // into a window that happens to extend that far.
    always_comb begin
        w_in_win    = (i_pix_x != 10'h3FF) && (i_pix_y != 10'h3FF) &&
                      (i_pix_x >= WX_LO) && ({1'b0, i_pix_x} < WX_HI) &&
                      (i_pix_y >= WY_LO) && ({1'b0, i_pix_y} < WY_HI);
        w_frame_end = (i_pix_x == X_LAST) && (i_pix_y == Y_LAST);
        w_idx       = OFS_W'(i_pix_x - WX_LO) + r_scroll_ofs;
    end

    // Frame divider and scroll offset; only moves at the last visible pixel
    // so a frame is never drawn with two different offsets.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frm_cnt    <= '0;
            r_scroll_ofs <= '0;
        end else if (w_frame_end && i_scroll_en) begin
            if (r_frm_cnt == CNT_TOP) begin
                r_frm_cnt    <= '0;
                r_scroll_ofs <= i_scroll_dir ? (r_scroll_ofs - STEP)
                                             : (r_scroll_ofs + STEP);
            end else begin
                r_frm_cnt <= r_frm_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: ROM row address (held outside the window), column index, flag.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_rom_addr <= '0;
            r_idx      <= '0;
            r_win_d1   <= 1'b0;
        end else begin
            if (w_in_win)
                o_rom_addr <= ADDR_W'(i_pix_y - WY_LO);
            r_idx    <= w_idx;
            r_win_d1 <= w_in_win;
        end
    end

    // Stage 2: align index and flag with the ROM's one-cycle read.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx_d2 <= '0;
            r_win_d2 <= 1'b0;
        end else begin
            r_idx_d2 <= r_idx;
            r_win_d2 <= r_win_d1;
        end
    end

`ifdef TFT_CHAR_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_TOP = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_vis;

    // Blink timer: counts every frame boundary regardless of scrolling.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLK_TOP) begin
                r_blink_cnt <= '0;
                r_blink_vis <= ~r_blink_vis;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    assign w_vis = r_blink_vis;
`else
    assign w_vis = 1'b1;
`endif

    // Output stage: MSB of the row word is the leftmost pixel, so the bit
    // index is CHAR_W-1-idx, which is ~idx for a power-of-two width.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            o_pix_data <= 16'h0000;
        else if (r_win_d2 && i_rom_data[~r_idx_d2] && w_vis)
            o_pix_data <= i_fg_color;
        else
            o_pix_data <= i_bg_color;
    end

    assign o_scroll_ofs = r_scroll_ofs;

endmodule

// File: tb/tb_tft_char_scroll.sv
// Directed bench for tft_char_scroll: static render, window edges, invalid
// coordinates, streaming, scroll wrap in both directions, hold, async reset
// and (when TFT_CHAR_BLINK_EN is defined) blink phases.
module tb_tft_char_scroll;

    localparam logic [15:0] FG = 16'hF800;
    localparam logic [15:0] BG = 16'h001F;

    logic         tft_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [9:0]   pix_x = 10'h3FF;
    logic [9:0]   pix_y = 10'h3FF;
    logic         scroll_en = 1'b0;
    logic         scroll_dir = 1'b0;
    logic [15:0]  fg_color = FG;
    logic [15:0]  bg_color = BG;
    logic [5:0]   rom_addr;
    logic [255:0] rom_data = '0;
    logic [15:0]  pix_data;
    logic [7:0]   scroll_ofs;

    logic [255:0] rom [64];

    int vec = 0;
    int err = 0;

    always #5 tft_clk = ~tft_clk;

    tft_char_scroll #(
        .SCROLL_DIV   (2),
        .SCROLL_STEP  (1),
        .BLINK_FRAMES (2)
    ) dut (
        .tft_clk      (tft_clk),
        .sys_rst_n    (sys_rst_n),
        .i_pix_x      (pix_x),
        .i_pix_y      (pix_y),
        .i_scroll_en  (scroll_en),
        .i_scroll_dir (scroll_dir),
        .i_fg_color   (fg_color),
        .i_bg_color   (bg_color),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_pix_data   (pix_data),
        .o_scroll_ofs (scroll_ofs)
    );

    // Synchronous one-cycle ROM model.
    always @(posedge tft_clk) rom_data <= rom[rom_addr];

    task automatic do_reset();
        @(negedge tft_clk);
        pix_x = 10'h3FF; pix_y = 10'h3FF;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge tft_clk);
        sys_rst_n = 1'b1;
    endtask

    // Present one coordinate, then invalid; returns pix_data 3 clocks later.
    task automatic render(input logic [9:0] x, input logic [9:0] y, output logic [15:0] d);
        @(negedge tft_clk);
        pix_x = x; pix_y = y;
        @(negedge tft_clk);
        pix_x = 10'h3FF; pix_y = 10'h3FF;
        repeat (2) @(negedge tft_clk);
        d = pix_data;
    endtask

    // n consecutive frame-boundary events.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge tft_clk);
            pix_x = 10'd479; pix_y = 10'd271;
        end
        @(negedge tft_clk);
        pix_x = 10'h3FF; pix_y = 10'h3FF;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #12;
        vec++; if (pix_data !== 16'h0000) begin err++; $display("FAIL reset_pix: got %h want 0000", pix_data); end
        vec++; if (rom_addr !== 6'd0) begin err++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        vec++; if (scroll_ofs !== 8'd0) begin err++; $display("FAIL reset_ofs: got %0d want 0", scroll_ofs); end
        do_reset();
    endtask

    task automatic test_static();
        logic [9:0]  xs [5];
        logic [15:0] ex [5];
        logic [15:0] d;
        xs = '{10'd112, 10'd367, 10'd113, 10'd111, 10'd368};
        ex = '{FG, FG, BG, BG, BG};
        for (int i = 0; i < 5; i++) begin
            render(xs[i], 10'd104, d);
            vec++; if (d !== ex[i]) begin err++; $display("FAIL static x=%0d: got %h want %h", xs[i], d, ex[i]); end
        end
        render(10'd200, 10'd167, d);
        vec++; if (d !== FG) begin err++; $display("FAIL last_row: got %h want %h", d, FG); end
    endtask

    task automatic test_outside();
        logic [9:0]  xs [4];
        logic [9:0]  ys [4];
        logic [15:0] d;
        xs = '{10'h3FF, 10'd112, 10'd112, 10'd200};
        ys = '{10'd104, 10'd103, 10'd168, 10'h3FF};
        render(10'd112, 10'd105, d);
        vec++; if (rom_addr !== 6'd1) begin err++; $display("FAIL addr_row1: got %0d want 1", rom_addr); end
        for (int i = 0; i < 4; i++) begin
            render(xs[i], ys[i], d);
            vec++; if (d !== BG) begin err++; $display("FAIL outside %0d: got %h want %h", i, d, BG); end
            vec++; if (rom_addr !== 6'd1) begin err++; $display("FAIL addr_hold %0d: got %0d want 1", i, rom_addr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ex [4];
        ex = '{FG, BG, FG, FG};
        for (int k = 0; k < 7; k++) begin
            @(negedge tft_clk);
            if (k >= 3) begin
                vec++; if (pix_data !== ex[k-3]) begin err++; $display("FAIL stream %0d: got %h want %h", k-3, pix_data, ex[k-3]); end
            end
            if (k < 4) begin pix_x = 10'(112 + k); pix_y = 10'd105; end
            else begin pix_x = 10'h3FF; pix_y = 10'h3FF; end
        end
    endtask

    task automatic test_scroll_left();
        logic [15:0] d;
        scroll_dir = 1'b0; scroll_en = 1'b1;
        frames(1);
        vec++; if (scroll_ofs !== 8'd0) begin err++; $display("FAIL left_f1: got %0d want 0", scroll_ofs); end
        frames(1);
        vec++; if (scroll_ofs !== 8'd1) begin err++; $display("FAIL left_f2: got %0d want 1", scroll_ofs); end
        scroll_en = 1'b0;
        render(10'd367, 10'd104, d);
        vec++; if (d !== FG) begin err++; $display("FAIL ofs1_x367: got %h want %h", d, FG); end
        render(10'd112, 10'd104, d);
        vec++; if (d !== BG) begin err++; $display("FAIL ofs1_x112: got %h want %h", d, BG); end
        scroll_en = 1'b1;
        frames(508);
        vec++; if (scroll_ofs !== 8'd255) begin err++; $display("FAIL left_f510: got %0d want 255", scroll_ofs); end
        frames(2);
        vec++; if (scroll_ofs !== 8'd0) begin err++; $display("FAIL left_f512: got %0d want 0", scroll_ofs); end
    endtask

    task automatic test_hold();
        frames(1);
        scroll_en = 1'b0;
        frames(10);
        vec++; if (scroll_ofs !== 8'd0) begin err++; $display("FAIL hold: got %0d want 0", scroll_ofs); end
        scroll_en = 1'b1;
        frames(1);
        vec++; if (scroll_ofs !== 8'd1) begin err++; $display("FAIL hold_resume: got %0d want 1", scroll_en); end
        frames(1);
        @(negedge tft_clk);
        pix_x = 10'd479; pix_y = 10'd271; scroll_en = 1'b1;
        @(negedge tft_clk);
        pix_x = 10'h3FF; pix_y = 10'h3FF; scroll_en = 1'b0;
        vec++; if (scroll_ofs !== 8'd2) begin err++; $display("FAIL en_fall_boundary: got %0d want 2", scroll_ofs); end
    endtask

    task automatic test_reset_midline();
        logic [15:0] d;
        render(10'd112, 10'd105, d);
        vec++; if (d !== FG) begin err++; $display("FAIL pre_reset_pix: got %h want %h", d, FG); end
        @(negedge tft_clk);
        pix_x = 10'd150; pix_y = 10'd110;
        #2 sys_rst_n = 1'b0;
        #1;
        vec++; if (pix_data !== 16'h0000) begin err++; $display("FAIL async_pix: got %h want 0000", pix_data); end
        vec++; if (scroll_ofs !== 8'd0) begin err++; $display("FAIL async_ofs: got %0d want 0", scroll_ofs); end
        vec++; if (rom_addr !== 6'd0) begin err++; $display("FAIL async_addr: got %0d want 0", rom_addr); end
        @(negedge tft_clk);
        pix_x = 10'h3FF; pix_y = 10'h3FF;
        sys_rst_n = 1'b1;
        render(10'd112, 10'd104, d);
        vec++; if (d !== FG) begin err++; $display("FAIL post_reset_pix: got %h want %h", d, FG); end
    endtask

    task automatic test_scroll_right();
        logic [15:0] d;
        scroll_dir = 1'b1; scroll_en = 1'b1;
        frames(2);
        vec++; if (scroll_ofs !== 8'd255) begin err++; $display("FAIL right_wrap: got %0d want 255", scroll_ofs); end
        scroll_en = 1'b0;
        render(10'd112, 10'd104, d);
        vec++; if (d !== FG) begin err++; $display("FAIL ofs255_x112: got %h want %h", d, FG); end
        scroll_en = 1'b1;
        frames(2);
        vec++; if (scroll_ofs !== 8'd254) begin err++; $display("FAIL right_step2: got %0d want 254", scroll_ofs); end
        scroll_en = 1'b0;
    endtask

    task automatic test_blink();
        logic [15:0] d;
        logic [15:0] ex [5];
`ifdef TFT_CHAR_BLINK_EN
        ex = '{FG, FG, BG, BG, FG};
`else
        ex = '{FG, FG, FG, FG, FG};
`endif
        do_reset();
        scroll_en = 1'b0;
        for (int f = 0; f < 5; f++) begin
            render(10'd112, 10'd104, d);
            vec++; if (d !== ex[f]) begin err++; $display("FAIL blink frame %0d: got %h want %h", f, d, ex[f]); end
            frames(1);
        end
    endtask

    initial begin
        for (int r = 0; r < 64; r++) rom[r] = '0;
        rom[0]  = {1'b1, 254'd0, 1'b1};
        rom[1]  = {4'b1011, 252'd0};
        rom[63] = '1;

        test_reset();
        test_static();
        test_outside();
        test_back_to_back();
        test_scroll_left();
        test_hold();
        test_reset_midline();
        test_scroll_right();
        test_blink();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
